// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: lane modes, fixed symbol tables and the byte
// popcount helper used by the video encoder.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_GUARD = 2'd3
  } tmds_mode_t;

  // Control period symbols indexed by {c1,c0}
  localparam logic [9:0] CTRL_SYM [0:3] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  // Data island symbols indexed by the aux nibble
  localparam logic [9:0] TERC4_SYM [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] GUARD_SYM_EVEN = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_ODD  = 10'b0100110011;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 builds q_m, stage 2 picks the symbol and tracks the
// running disparity, optional stage 3 registers the symbol once more.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int LANE_IDX = 0,
  parameter int OUT_REG  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic [3:0] i_aux,
  input  logic       i_s1_valid,
  input  tmds_mode_t i_s1_mode,
  output logic [9:0] o_tmds
);

  // Guard band polarity alternates with the lane position modulo 3
  localparam logic [9:0] GUARD_SYM =
    (((LANE_IDX % 3) % 2) == 0) ? GUARD_SYM_EVEN : GUARD_SYM_ODD;

  logic [3:0]        w_n1d;
  logic              w_use_xnor;
  logic [8:0]        w_qm;

  logic [8:0]        r_qm;
  logic [1:0]        r_ctrl;
  logic [3:0]        r_aux;

  logic [3:0]        w_n1;
  logic              w_q8;
  logic signed [4:0] w_diff;
  logic signed [4:0] w_q8x2;
  logic signed [4:0] w_nq8x2;
  logic [9:0]        w_sym_nxt;
  logic signed [4:0] w_cnt_nxt;

  logic [9:0]        r_sym;
  logic signed [4:0] r_cnt;

  // Transition-minimising q_m: XNOR chain when the byte is ones-heavy
  always_comb begin
    logic [7:0] v_qm;
    w_n1d      = ones8(i_data);
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !i_data[0]);
    v_qm       = 8'd0;
    v_qm[0]    = i_data[0];
    for (int i = 1; i < 8; i++) begin
      v_qm[i] = w_use_xnor ? ~(v_qm[i-1] ^ i_data[i]) : (v_qm[i-1] ^ i_data[i]);
    end
    w_qm = {~w_use_xnor, v_qm};
  end

  // Stage 1 registers: q_m plus the side-band inputs for the same word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_qm   <= '0;
      r_ctrl <= '0;
      r_aux  <= '0;
    end else begin
      r_qm   <= w_qm;
      r_ctrl <= i_ctrl;
      r_aux  <= i_aux;
    end
  end

  // Symbol selection and disparity update; 5-bit wraparound is exact because
  // the final count always lands back inside -10..+10
  always_comb begin
    w_n1      = ones8(r_qm[7:0]);
    w_q8      = r_qm[8];
    w_diff    = $signed({w_n1, 1'b0}) - 5'sd8;
    w_q8x2    = $signed({3'b000, w_q8, 1'b0});
    w_nq8x2   = $signed({3'b000, ~w_q8, 1'b0});
    w_sym_nxt = CTRL_SYM[0];
    w_cnt_nxt = r_cnt;
    if (i_s1_valid) begin
      case (i_s1_mode)
        MODE_VIDEO: begin
          if ((r_cnt == 5'sd0) || (w_n1 == 4'd4)) begin
            w_sym_nxt = {~w_q8, w_q8, (w_q8 ? r_qm[7:0] : ~r_qm[7:0])};
            w_cnt_nxt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
          end else if (((r_cnt > 5'sd0) && (w_n1 > 4'd4)) ||
                       ((r_cnt < 5'sd0) && (w_n1 < 4'd4))) begin
            w_sym_nxt = {1'b1, w_q8, ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_q8x2 - w_diff;
          end else begin
            w_sym_nxt = {1'b0, w_q8, r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_diff - w_nq8x2;
          end
        end
        MODE_CTRL: begin
          w_sym_nxt = CTRL_SYM[r_ctrl];
          w_cnt_nxt = 5'sd0;
        end
        MODE_TERC4: begin
          w_sym_nxt = TERC4_SYM[r_aux];
          w_cnt_nxt = 5'sd0;
        end
        default: begin
          w_sym_nxt = GUARD_SYM;
          w_cnt_nxt = 5'sd0;
        end
      endcase
    end
  end

  // Stage 2 registers: encoded symbol and running disparity
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sym <= '0;
      r_cnt <= '0;
    end else begin
      r_sym <= w_sym_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [9:0] r_out;
      // Extra output stage for timing closure toward the serialiser
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_out <= '0;
        else       r_out <= r_sym;
      end
      assign o_tmds = r_out;
    end else begin : g_no_out_reg
      assign o_tmds = r_sym;
    end
  endgenerate

endmodule

// File: rtl/tmds_multi_encoder.sv
// Multi-lane TMDS encoder: NUM_CH independent lanes sharing one valid/mode
// pipeline. Latency is 2 cycles, or 3 with OUT_REG=1.
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int OUT_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  tmds_mode_t            i_mode,
  input  logic [NUM_CH*8-1:0]   i_data,
  input  logic [NUM_CH*2-1:0]   i_ctrl,
  input  logic [NUM_CH*4-1:0]   i_aux,
  output logic [NUM_CH*10-1:0]  o_tmds,
  output logic                  o_valid
);

  logic       r_s1_valid;
  tmds_mode_t r_s1_mode;
  logic       r_s2_valid;

  // Shared word qualifiers travelling alongside the lane pipelines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_CTRL;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_mode  <= i_mode;
      r_s2_valid <= r_s1_valid;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_vld_reg
      logic r_s3_valid;
      // Valid follows the optional output stage
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_s3_valid <= 1'b0;
        else       r_s3_valid <= r_s2_valid;
      end
      assign o_valid = r_s3_valid;
    end else begin : g_vld_direct
      assign o_valid = r_s2_valid;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tmds_lane #(
        .LANE_IDX (k),
        .OUT_REG  (OUT_REG)
      ) u_lane (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data[8*k +: 8]),
        .i_ctrl     (i_ctrl[2*k +: 2]),
        .i_aux      (i_aux[4*k +: 4]),
        .i_s1_valid (r_s1_valid),
        .i_s1_mode  (r_s1_mode),
        .o_tmds     (o_tmds[10*k +: 10])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Directed and randomised checks of tmds_multi_encoder with NUM_CH=3,
// one instance per OUT_REG setting driven from the same inputs.
module tb_tmds_multi_encoder;
  import tmds_pkg::*;

  localparam int MAXC = 10200;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GE  = 10'b1011001100;
  localparam logic [9:0] GO  = 10'b0100110011;
  localparam logic [9:0] TB_CTRL [0:3] = '{C00, C01, C10, C11};
  localparam logic [9:0] TB_TERC [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  logic        clk;
  logic        rst;
  logic        i_valid;
  tmds_mode_t  i_mode;
  logic [23:0] i_data;
  logic [5:0]  i_ctrl;
  logic [11:0] i_aux;
  logic [29:0] o_tmds0, o_tmds1;
  logic        o_valid0, o_valid1;

  logic [29:0] exp_sym [0:MAXC-1];
  logic        exp_v   [0:MAXC-1];
  logic        exp_chk [0:MAXC-1];
  logic        in_v    [0:MAXC-1];
  tmds_mode_t  in_mode [0:MAXC-1];
  logic [23:0] in_data [0:MAXC-1];

  int cyc;
  int checks;
  int errors;
  int rd [0:2];
  int m_cnt [0:2];
  bit rd_on;

  tmds_multi_encoder #(.NUM_CH(3), .OUT_REG(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_mode(i_mode),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_aux(i_aux),
    .o_tmds(o_tmds0), .o_valid(o_valid0)
  );

  tmds_multi_encoder #(.NUM_CH(3), .OUT_REG(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_mode(i_mode),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_aux(i_aux),
    .o_tmds(o_tmds1), .o_valid(o_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] rep3(input logic [9:0] s);
    return {s, s, s};
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d = 8'd0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  task automatic model_video(input logic [7:0] d, input int cin,
                             output logic [9:0] sym, output int cout);
    int n1d, n1, n0;
    logic xn, q8;
    logic [7:0] q;
    n1d = $countones(d);
    xn = (n1d > 4) || ((n1d == 4) && (d[0] == 1'b0));
    q = 8'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = ~xn;
    n1 = $countones(q);
    n0 = 8 - n1;
    if ((cin == 0) || (n1 == n0)) begin
      sym  = {~q8, q8, (q8 ? q : ~q)};
      cout = q8 ? (cin + n1 - n0) : (cin + n0 - n1);
    end else if (((cin > 0) && (n1 > n0)) || ((cin < 0) && (n0 > n1))) begin
      sym  = {1'b1, q8, ~q};
      cout = cin + (q8 ? 2 : 0) + n0 - n1;
    end else begin
      sym  = {1'b0, q8, q};
      cout = cin + n1 - n0 - (q8 ? 0 : 2);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tmds0"},  32'(o_tmds0),  32'd0);
    chk({tag, "_valid0"}, 32'(o_valid0), 32'd0);
    chk({tag, "_tmds1"},  32'(o_tmds1),  32'd0);
    chk({tag, "_valid1"}, 32'(o_valid1), 32'd0);
  endtask

  task automatic check_outputs();
    int i0, i1;
    logic [9:0] s;
    logic in_range;
    if (cyc >= 2) begin
      i0 = cyc - 2;
      if (exp_chk[i0]) begin
        chk($sformatf("sym_lat2 w%0d", i0), 32'(o_tmds0), 32'(exp_sym[i0]));
        chk($sformatf("vld_lat2 w%0d", i0), 32'(o_valid0), 32'(exp_v[i0]));
        if (in_v[i0]) begin
          for (int k = 0; k < 3; k++) begin
            s = o_tmds0[k*10 +: 10];
            if (in_mode[i0] == MODE_VIDEO) begin
              chk($sformatf("decode w%0d lane%0d", i0, k), 32'(dec(s)),
                  32'(in_data[i0][k*8 +: 8]));
              if (rd_on) begin
                rd[k] = rd[k] + 2 * $countones(s) - 10;
                in_range = (rd[k] >= -10) && (rd[k] <= 10);
                chk($sformatf("disparity w%0d lane%0d rd=%0d", i0, k, rd[k]),
                    32'(in_range), 32'd1);
              end
            end else begin
              rd[k] = 0;
            end
          end
        end
      end
    end
    if (cyc >= 3) begin
      i1 = cyc - 3;
      if (exp_chk[i1]) begin
        chk($sformatf("sym_lat3 w%0d", i1), 32'(o_tmds1), 32'(exp_sym[i1]));
        chk($sformatf("vld_lat3 w%0d", i1), 32'(o_valid1), 32'(exp_v[i1]));
      end
    end
  endtask

  task automatic tick(input logic v, input tmds_mode_t m, input logic [23:0] d,
                      input logic [5:0] c, input logic [11:0] a,
                      input logic [29:0] e, input logic ck);
    @(negedge clk);
    check_outputs();
    i_valid = v;
    i_mode  = m;
    i_data  = d;
    i_ctrl  = c;
    i_aux   = a;
    exp_sym[cyc] = e;
    exp_v[cyc]   = v;
    exp_chk[cyc] = ck;
    in_v[cyc]    = v;
    in_mode[cyc] = m;
    in_data[cyc] = d;
    cyc++;
  endtask

  initial begin
    logic        v;
    tmds_mode_t  m;
    logic [23:0] d;
    logic [5:0]  c;
    logic [11:0] a;
    logic [29:0] e;
    logic [9:0]  s;
    int          nc;

    cyc = 0; checks = 0; errors = 0; rd_on = 1'b0;
    for (int k = 0; k < 3; k++) begin rd[k] = 0; m_cnt[k] = 0; end
    rst = 1'b0; i_valid = 1'b0; i_mode = MODE_CTRL;
    i_data = '0; i_ctrl = '0; i_aux = '0;
    #1 rst = 1'b1;
    #2 chk_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Directed words, all lanes identical unless noted
    tick(1'b0, MODE_CTRL,  24'h000000, 6'b0, 12'h0, rep3(C00), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h100), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h3FF), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h100), 1'b1);
    tick(1'b1, MODE_CTRL,  24'h000000, 6'b111001, 12'h0, {C11, C10, C01}, 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h100), 1'b1);
    tick(1'b0, MODE_VIDEO, 24'hFFFFFF, 6'b0, 12'h0, rep3(C00), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h3FF), 1'b1);
    tick(1'b1, MODE_TERC4, 24'h000000, 6'b0, 12'h000, rep3(10'b1010011100), 1'b1);
    tick(1'b1, MODE_TERC4, 24'h000000, 6'b0, 12'hFFF, rep3(10'b1011000011), 1'b1);
    tick(1'b1, MODE_TERC4, 24'h000000, 6'b0, 12'hA51,
         {10'b0110011100, 10'b0100011110, 10'b1001100011}, 1'b1);
    tick(1'b1, MODE_GUARD, 24'h000000, 6'b0, 12'h0, {GE, GO, GE}, 1'b1);
    tick(1'b1, MODE_VIDEO, 24'hFFFFFF, 6'b0, 12'h0, rep3(10'h200), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'hFFFFFF, 6'b0, 12'h0, rep3(10'h0FF), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h555555, 6'b0, 12'h0, rep3(10'h133), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h101010, 6'b0, 12'h0, rep3(10'h1F0), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h010101, 6'b0, 12'h0, rep3(10'h1FF), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h010101, 6'b0, 12'h0, rep3(10'h300), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h0F0F0F, 6'b0, 12'h0, rep3(10'h105), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h1E1E1E, 6'b0, 12'h0, rep3(10'h25F), 1'b1);
    for (int i = 0; i < 3; i++)
      tick(1'b0, MODE_CTRL, 24'h0, 6'b0, 12'h0, rep3(C00), 1'b1);

    // Mid-stream reset: two words in flight are discarded
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h100), 1'b0);
    tick(1'b1, MODE_VIDEO, 24'h000000, 6'b0, 12'h0, rep3(10'h3FF), 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("reset_async");
    i_valid = 1'b1; i_mode = MODE_VIDEO; i_data = 24'hFFFFFF;
    @(negedge clk);
    chk_zero("reset_held");
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0; i_mode = MODE_CTRL; i_data = '0;
    for (int i = 0; i < cyc; i++) exp_chk[i] = 1'b0;
    tick(1'b0, MODE_CTRL,  24'h0, 6'b0, 12'h0, rep3(C00), 1'b1);
    tick(1'b0, MODE_CTRL,  24'h0, 6'b0, 12'h0, rep3(C00), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h0, 6'b0, 12'h0, rep3(10'h100), 1'b1);
    tick(1'b1, MODE_VIDEO, 24'h0, 6'b0, 12'h0, rep3(10'h3FF), 1'b1);
    tick(1'b1, MODE_CTRL,  24'h0, 6'b0, 12'h0, rep3(C00), 1'b1);

    // Random words with random modes against the reference model
    rd_on = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      v = ($urandom_range(0, 15) != 0);
      m = tmds_mode_t'($urandom_range(0, 3));
      d = 24'($urandom);
      c = 6'($urandom);
      a = 12'($urandom);
      e = '0;
      for (int k = 0; k < 3; k++) begin
        if (!v) begin
          s = C00;
        end else begin
          case (m)
            MODE_VIDEO: begin
              model_video(d[k*8 +: 8], m_cnt[k], s, nc);
              m_cnt[k] = nc;
            end
            MODE_CTRL:  begin s = TB_CTRL[c[k*2 +: 2]]; m_cnt[k] = 0; end
            MODE_TERC4: begin s = TB_TERC[a[k*4 +: 4]]; m_cnt[k] = 0; end
            default:    begin s = ((k % 3) % 2 == 0) ? GE : GO; m_cnt[k] = 0; end
          endcase
        end
        e[k*10 +: 10] = s;
      end
      tick(v, m, d, c, a, e, 1'b1);
    end
    for (int i = 0; i < 4; i++)
      tick(1'b0, MODE_CTRL, 24'h0, 6'b0, 12'h0, rep3(C00), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_multi_encoder.md
TMDS_MULTI_ENCODER -- requirements
Module: tmds_multi_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent TMDS lanes, legal range 1..8.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 adds an output register stage, 0 removes it.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit: the input word is valid this cycle.
REQ-006 SHALL have port i_mode, input, 2 bits, type tmds_mode_t: CTRL=0, VIDEO=1, TERC4=2, GUARD=3.
REQ-007 SHALL have port i_data, input, NUM_CH*8 bits: video byte per lane; lane k uses bits [8k+7:8k].
REQ-008 SHALL have port i_ctrl, input, NUM_CH*2 bits: control pair per lane ({vs,hs} on lane 0).
REQ-009 SHALL have port i_aux, input, NUM_CH*4 bits: TERC4 nibble per lane.
REQ-010 SHALL have port o_tmds, output, NUM_CH*10 bits: encoded symbol per lane.
REQ-011 SHALL have port o_valid, output, 1 bit: o_tmds holds a valid symbol.

Function
REQ-012 Latency SHALL be 2 cycles when OUT_REG=0 and 3 cycles when OUT_REG=1, for all modes; o_valid SHALL be i_valid delayed by the same latency.
REQ-013 Stage 1 (VIDEO) SHALL compute q_m[8:0] using N1d = ones(D).
 - XNOR chain with q_m[8]=0 when N1d>4, or N1d==4 and D[0]==0.
 - Otherwise XOR chain with q_m[8]=1.
 - q_m[0]=D[0].
REQ-014 Stage 2 (VIDEO) SHALL compute N1=ones(q_m[7:0]) and N0=8-N1, then apply the first matching rule:
 - cnt==0 or N1==N0: out={~q_m[8],q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt+= q_m[8]?(N1-N0):(N0-N1).
 - (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1,q_m[8],~q_m[7:0]}; cnt+=2*q_m[8]+(N0-N1).
 - else: out={0,q_m[8],q_m[7:0]}; cnt+=(N1-N0)-2*(~q_m[8]).
REQ-015 cnt SHALL be a signed 5-bit register per lane, held within -10..+10 by the algorithm.
REQ-016 In CTRL mode, o_tmds SHALL be the fixed symbol for i_ctrl: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-017 In TERC4 mode, o_tmds SHALL be the symbol for i_aux, 0..F in order: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-018 In GUARD mode, lane k SHALL output 1011001100 when (k mod 3) is even, else 0100110011.
REQ-019 In CTRL, TERC4 and GUARD modes, cnt SHALL be cleared to 0 when that stage-2 word is processed.
REQ-020 Cycles with i_valid=0 SHALL leave cnt unchanged and SHALL output the CTRL 00 symbol with o_valid=0.
REQ-021 A mode change on consecutive valid cycles SHALL produce no gap or corrupted symbol; each word is encoded by its own mode.
REQ-022 All lanes SHALL be independent; the same inputs on every lane SHALL yield identical symbols.

Reset
REQ-023 While i_rst=1, all pipeline registers, o_tmds and every cnt SHALL be 0, and o_valid SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight words; the first valid input after deassertion SHALL appear after the full latency with cnt=0.

Structure
REQ-025 Package tmds_pkg SHALL hold:
 - tmds_mode_t;
 - the 4 control symbols, 16 TERC4 symbols and 2 guard symbols as constants;
 - the ones-count function.
REQ-026 Sub-module tmds_lane SHALL encode one lane, including its cnt; the top SHALL instantiate NUM_CH copies with a generate loop and hold the shared valid pipeline.

Verification
REQ-027 Assert i_rst between clock edges -> o_tmds=0 and o_valid=0 immediately, without waiting for a clock edge.
REQ-028 VIDEO, lane data 0x00 for 3 cycles from cnt=0 -> o_tmds 0x100, 0x3FF, 0x100; cnt -8, +2, -6.
REQ-029 CTRL, i_ctrl lane0=01, after VIDEO 0x00 -> 0010101011 at latency; next VIDEO 0x00 -> 0x100, proving cnt was cleared.
REQ-030 TERC4, i_aux 0x0 then 0xF -> 1010011100 then 1011000011.
REQ-031 GUARD with NUM_CH=3 -> lanes 0/1/2 = 1011001100/0100110011/1011001100.
REQ-032 10k random valid words with random modes, OUT_REG 0 and 1 -> symbols match the bench model, a decoder recovers every byte, and cnt stays within ±10.
